axis_detection_thresholder: RTL

- Downstream stage of the target-detection core; consumes the 32-bit per-pixel detection score stream (M_AXIS_DOUT of the system).
- Compares each score against a run-time threshold and emits a compact hit list of pixel indices, closed by a per-frame trailer word carrying the hit count.
- An internal hit FIFO absorbs bursts of detections; backpressure is applied upstream only when the FIFO cannot accept a worst-case write.

---
 rtl/axis_detection_thresholder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axis_detection_thresholder.sv
// Thresholds a per-pixel score stream into a hit-index list plus a per-frame trailer.
// Optional DETECT_SCORE_OUT_EN appends the raw score after every hit index word.
module axis_detection_thresholder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] THRESHOLD,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  FRAME_DONE,
  output logic [DATA_WIDTH-2:0] HIT_COUNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = DATA_WIDTH - 1;
`ifdef DETECT_SCORE_OUT_EN
  localparam int unsigned MIN_FREE  = 3;
  localparam int unsigned HIT_WORDS = 2;
`else
  localparam int unsigned MIN_FREE  = 2;
  localparam int unsigned HIT_WORDS = 1;
`endif

  typedef enum logic {RUN, TRAIL} state_t;

  state_t                state_q, state_d;
  logic                  frame_active_q, frame_active_d;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         hits_q, hits_d;
  logic [IW-1:0]         hit_count_q, hit_count_d;
  logic                  done_q, done_d;

  // FIFO entries carry {tlast, tdata}
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   head_q, head_d;
  logic                  mvalid_q, mvalid_d;
  logic                  tready_q, tready_d;

  logic                  accept;
  logic                  is_hit;
  logic                  pop;
  logic [1:0]            n_push;
  logic [DATA_WIDTH:0]   word0;
`ifdef DETECT_SCORE_OUT_EN
  logic [DATA_WIDTH:0]   word1;
`endif

  // Frame control, FIFO bookkeeping and next values of every registered output
  always_comb begin
    state_d        = state_q;
    frame_active_d = frame_active_q;
    idx_d          = idx_q;
    hits_d         = hits_q;
    hit_count_d    = hit_count_q;
    done_d         = 1'b0;
    n_push         = 2'd0;
    word0          = {1'b0, 1'b0, idx_q};
`ifdef DETECT_SCORE_OUT_EN
    word1          = {1'b0, S_AXIS_TDATA};
`endif
    accept = (state_q == RUN) && tready_q && S_AXIS_TVALID;
    is_hit = S_AXIS_TDATA >= thr_q;
    pop    = mvalid_q && M_AXIS_TREADY;

    case (state_q)
      RUN: begin
        if (accept) begin
          frame_active_d = 1'b1;
          idx_d          = idx_q + IW'(1);
          if (is_hit) begin
            n_push = 2'(HIT_WORDS);
            hits_d = (hits_q == '1) ? hits_q : hits_q + IW'(1);
          end
          if (S_AXIS_TLAST) state_d = TRAIL;
        end
      end
      TRAIL: begin
        n_push         = 2'd1;
        word0          = {1'b1, 1'b1, hits_q};
        done_d         = 1'b1;
        hit_count_d    = hits_q;
        idx_d          = '0;
        hits_d         = '0;
        frame_active_d = 1'b0;
        state_d        = RUN;
      end
      default: state_d = RUN;
    endcase

    cnt_d = cnt_q + CW'(n_push) - CW'(pop);
    wr_d  = wr_q + AW'(n_push);
    rd_d  = rd_q + AW'(pop);

    // A freshly pushed word becomes the head when nothing older survives this cycle
    if (cnt_d == '0)               head_d = '0;
    else if (cnt_q == CW'(pop))    head_d = word0;
    else                           head_d = mem[rd_d];
    mvalid_d = cnt_d != '0;
    tready_d = (state_d == RUN) && (cnt_d <= CW'(FIFO_DEPTH - MIN_FREE));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= RUN;
      frame_active_q <= 1'b0;
      thr_q          <= '0;
      idx_q          <= '0;
      hits_q         <= '0;
      hit_count_q    <= '0;
      done_q         <= 1'b0;
      wr_q           <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      head_q         <= '0;
      mvalid_q       <= 1'b0;
      tready_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_active_q <= frame_active_d;
      // Reload during the trailer cycle too, so a back-to-back frame sees the new value
      if (!frame_active_q || state_q == TRAIL) thr_q <= THRESHOLD;
      idx_q          <= idx_d;
      hits_q         <= hits_d;
      hit_count_q    <= hit_count_d;
      done_q         <= done_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      head_q         <= head_d;
      mvalid_q       <= mvalid_d;
      tready_q       <= tready_d;
    end
  end

  // Storage array; pointers above define which entries are live
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_q] <= word0;
`ifdef DETECT_SCORE_OUT_EN
    if (n_push == 2'd2) mem[wr_q + AW'(1)] <= word1;
`endif
  end

  assign S_AXIS_TREADY = tready_q;
  assign M_AXIS_TDATA  = head_q[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = head_q[DATA_WIDTH];
  assign M_AXIS_TVALID = mvalid_q;
  assign FRAME_DONE    = done_q;
  assign HIT_COUNT     = hit_count_q;

endmodule
